aes_stream_buffer: RTL and testbench

- Parametrised successor to the single-entry AES input/output buffers.
- Sits between the system interface and aes_cipher_top.
- Queues up to IN_DEPTH {text,key} jobs with valid/ready, issues one job at a time to the cipher core via a ld pulse, and collects core results on done into an OUT_DEPTH result FIFO with valid/ready backpressure.
- Never issues a job without a guaranteed output slot, so no result is ever dropped.

---
 rtl/aes_stream_buffer.sv | 140 ++++++++++++++
 tb/tb_aes_stream_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_buffer.sv
// Job/result buffering between a system stream interface and an iterative AES core.
// Input jobs queue in a FIFO; one job runs at a time; its output slot is reserved before it starts.
module aes_stream_buffer #(
  parameter int DATA_W    = 128,
  parameter int KEY_W     = 128,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_text,
  input  logic [KEY_W-1:0]                 in_key,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_text,
  output logic                             core_ld,
  output logic [DATA_W-1:0]                core_text,
  output logic [KEY_W-1:0]                 core_key,
  input  logic                             core_done,
  input  logic [DATA_W-1:0]                core_text_out,
  output logic                             busy,
  output logic [$clog2(IN_DEPTH+1)-1:0]    in_count,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   out_count,
  output logic                             err_spurious
);

  localparam int IPW = $clog2(IN_DEPTH);
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BUSY
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] in_text_mem [IN_DEPTH];
  logic [KEY_W-1:0]  in_key_mem  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem     [OUT_DEPTH];

  logic [IPW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [ICW-1:0]    in_cnt_q, in_cnt_d;
  logic [OPW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OCW-1:0]    out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] core_text_q, core_text_d;
  logic [KEY_W-1:0]  core_key_q, core_key_d;
  logic              err_q, err_d;

  logic in_push, issue, out_push, out_pop;

  assign in_ready  = (in_cnt_q != ICW'(IN_DEPTH));
  assign out_valid = (out_cnt_q != '0);
  assign in_push   = in_valid && in_ready;
  assign out_pop   = out_valid && out_ready;
  // The result slot is claimed here, so the push on done can never overflow.
  assign issue     = (state_q == ST_IDLE) && (in_cnt_q != '0) && (out_cnt_q != OCW'(OUT_DEPTH));
  assign out_push  = core_done && (state_q != ST_IDLE);

  assign out_text     = out_valid ? out_mem[out_rd_q] : '0;
  assign core_ld      = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE);
  assign core_text    = core_text_q;
  assign core_key     = core_key_q;
  assign in_count     = in_cnt_q;
  assign out_count    = out_cnt_q;
  assign err_spurious = err_q;

  always_comb begin
    state_d     = state_q;
    in_wr_d     = in_wr_q;
    in_rd_d     = in_rd_q;
    out_wr_d    = out_wr_q;
    out_rd_d    = out_rd_q;
    core_text_d = core_text_q;
    core_key_d  = core_key_q;
    err_d       = err_q;
    in_cnt_d    = in_cnt_q + ICW'(in_push) - ICW'(issue);
    out_cnt_d   = out_cnt_q + OCW'(out_push) - OCW'(out_pop);

    if (in_push)  in_wr_d  = in_wr_q + 1'b1;
    if (out_push) out_wr_d = out_wr_q + 1'b1;
    if (out_pop)  out_rd_d = out_rd_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (core_done) err_d = 1'b1;
        if (issue) begin
          in_rd_d     = in_rd_q + 1'b1;
          core_text_d = in_text_mem[in_rd_q];
          core_key_d  = in_key_mem[in_rd_q];
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: state_d = core_done ? ST_IDLE : ST_BUSY;
      ST_BUSY: if (core_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_cnt_q    <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      core_text_q <= '0;
      core_key_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      in_cnt_q    <= in_cnt_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      core_text_q <= core_text_d;
      core_key_q  <= core_key_d;
      err_q       <= err_d;
    end
  end

  // Storage arrays carry no reset; occupancy counters decide what is meaningful.
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_text_mem[in_wr_q] <= in_text;
      in_key_mem[in_wr_q]  <= in_key;
    end
    if (out_push) out_mem[out_wr_q] <= core_text_out;
  end

endmodule

// File: tb/tb_aes_stream_buffer.sv
// Scoreboarded bench for aes_stream_buffer with a behavioural cipher-core model.
// Expected results are queued at job acceptance; a negedge monitor checks each popped result.
module tb_aes_stream_buffer;

  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_text = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_text;
  logic         core_ld;
  logic [127:0] core_text;
  logic [127:0] core_key;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         busy;
  logic [2:0]   in_count;
  logic [2:0]   out_count;
  logic         err_spurious;

  logic         model_done = 1'b0;
  logic [127:0] model_text = '0;
  logic         man_done = 1'b0;
  logic [127:0] man_text = '0;

  assign core_done     = model_done | man_done;
  assign core_text_out = man_done ? man_text : model_text;

  int checks = 0;
  int errors = 0;
  int ld_count = 0;
  int max_in_count = 0;
  int core_lat = 10;
  bit core_auto = 1'b1;

  logic [127:0] exp_q[$];
  logic [255:0] job_q[$];

  always #5 clk = ~clk;

  aes_stream_buffer #(
    .DATA_W(128), .KEY_W(128), .IN_DEPTH(4), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .core_ld(core_ld), .core_text(core_text), .core_key(core_key),
    .core_done(core_done), .core_text_out(core_text_out),
    .busy(busy), .in_count(in_count), .out_count(out_count),
    .err_spurious(err_spurious)
  );

  // Stand-in cipher: the known AES-128 vector, otherwise text XOR half-swapped key.
  function automatic logic [127:0] cipher(input logic [127:0] t, input logic [127:0] k);
    if (t == AES_PT && k == AES_KEY) return AES_CT;
    return t ^ {k[63:0], k[127:64]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [127:0] t, input logic [127:0] k);
    int budget;
    bit accepted;
    budget = 0;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_text = t;
    in_key = k;
    while (!accepted && budget < 300) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end else begin
        budget++;
      end
    end
    in_valid = 1'b0;
    if (accepted) begin
      exp_q.push_back(cipher(t, k));
      job_q.push_back({t, k});
      $display("job  accepted text=%h key=%h", t, k);
    end else begin
      timeout("send_job");
    end
  endtask

  // Cipher-core model: checks the issued job, then answers after core_lat cycles.
  initial begin
    logic [255:0] job;
    forever begin
      @(negedge clk);
      if (core_ld) begin
        ld_count++;
        if (job_q.size() == 0) begin
          timeout("core_ld_without_job");
        end else begin
          job = job_q.pop_front();
          check("core_job_text", core_text, job[255:128]);
          check("core_job_key", core_key, job[127:0]);
        end
        if (core_auto) begin
          job = {core_text, core_key};
          repeat (core_lat) @(posedge clk);
          #1;
          model_done = 1'b1;
          model_text = cipher(job[255:128], job[127:0]);
          @(posedge clk);
          #1;
          model_done = 1'b0;
        end
      end
    end
  end

  // Output monitor: every accepted result is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (int'(in_count) > max_in_count) max_in_count = int'(in_count);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) timeout("result_without_job");
        else check("result", out_text, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_core_ld"}, 128'(core_ld), 128'd0);
    check({tag, "_core_text"}, core_text, 128'd0);
    check({tag, "_core_key"}, core_key, 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_in_count"}, 128'(in_count), 128'd0);
    check({tag, "_out_count"}, 128'(out_count), 128'd0);
    check({tag, "_err"}, 128'(err_spurious), 128'd0);
    check({tag, "_out_text"}, out_text, 128'd0);
  endtask

  initial begin
    int n;
    int ld_base;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b1;
    tick();

    // Single job: latency, one ld pulse, result, pop
    core_lat = 10;
    ld_base = ld_count;
    send_job(AES_PT, AES_KEY);
    check("t1_in_count_accept", 128'(in_count), 128'd1);
    check("t1_ld_low_accept", 128'(core_ld), 128'd0);
    tick();
    check("t1_ld_high", 128'(core_ld), 128'd1);
    check("t1_busy_load", 128'(busy), 128'd1);
    check("t1_in_count_issued", 128'(in_count), 128'd0);
    tick();
    check("t1_ld_single", 128'(core_ld), 128'd0);
    check("t1_busy_wait", 128'(busy), 128'd1);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    if (!out_valid) timeout("t1_out_valid");
    check("t1_out_count", 128'(out_count), 128'd1);
    check("t1_out_text", out_text, AES_CT);
    check("t1_ld_pulses", 128'(ld_count - ld_base), 128'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_out_count_pop", 128'(out_count), 128'd0);

    // Five jobs back-to-back against a slow core
    core_lat = 20;
    out_ready = 1'b1;
    max_in_count = 0;
    for (int i = 0; i < 5; i++)
      send_job({32'hA5A5_0000 + 32'(i), 96'h0123_4567_89ab_cdef_0000_1111},
               {96'hfeed_beef_cafe_f00d_1234_5678, 32'h0000_0100 + 32'(i)});
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 800) begin tick(); n++; end
    if (exp_q.size() != 0) timeout("t2_drain");
    check("t2_in_count_max", 128'(max_in_count), 128'd4);
    out_ready = 1'b0;

    // Output backpressure: four jobs issue, the rest park
    core_lat = 3;
    ld_base = ld_count;
    for (int i = 0; i < 6; i++)
      send_job({96'h1111_2222_3333_4444_5555_6666, 32'h0000_00C0 + 32'(i)},
               {32'h0F0F_0000 + 32'(i), 96'h9999_8888_7777_6666_5555_4444});
    repeat (60) tick();
    check("t3_ld_parked", 128'(ld_count - ld_base), 128'd4);
    check("t3_out_count_full", 128'(out_count), 128'd4);
    check("t3_in_count", 128'(in_count), 128'd2);
    check("t3_idle", 128'(busy), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (20) tick();
    check("t3_fifth_issued", 128'(ld_count - ld_base), 128'd5);
    check("t3_out_count_refull", 128'(out_count), 128'd4);

    // Done and pop on the same edge with the reserved last slot in use
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    @(posedge clk);
    #2;
    while (!core_done && n < 50) begin @(posedge clk); #2; n++; end
    if (!core_done) timeout("t4_done");
    check("t4_out_count_before", 128'(out_count), 128'd3);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #1;
    check("t4_out_count_same_edge", 128'(out_count), 128'd3);
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin tick(); n++; end
    if (exp_q.size() != 0) timeout("t4_drain");
    out_ready = 1'b0;
    check("t4_out_count_empty", 128'(out_count), 128'd0);

    // Reset mid-job, then a late done is spurious
    core_auto = 1'b0;
    send_job(128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 128'h0);
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    if (!busy) timeout("t5_busy");
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_values("t5_rst");
    tick();
    rst = 1'b1;
    exp_q.delete();
    job_q.delete();
    tick();
    man_text = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t5_out_count", 128'(out_count), 128'd0);
    check("t5_out_valid", 128'(out_valid), 128'd0);
    check("t5_err", 128'(err_spurious), 128'd1);
    check("t5_busy", 128'(busy), 128'd0);
    core_auto = 1'b1;

    // Spurious done while idle after a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_err_cleared", 128'(err_spurious), 128'd0);
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t6_err_set", 128'(err_spurious), 128'd1);
    check("t6_out_count", 128'(out_count), 128'd0);
    repeat (5) tick();
    check("t6_err_sticky", 128'(err_spurious), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
